// File: rtl/weight_addr_sequencer.sv
// weight_addr_sequencer: steps the weight BRAM read address through num_filters back-to-back filters
module weight_addr_sequencer #(
  parameter int ADDR_W = 10,
  parameter int Dimension = 16,
  parameter int FW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en,
  input  logic              rewind,
  input  logic              next_filter,
  input  logic [4:0]        kernel_size,
  input  logic [FW-1:0]     num_filters,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] addr,
  output logic              weight_counter_done,
  output logic              weight_flag_1per16,
  output logic [FW-1:0]     filter_idx,
  output logic              all_filters_done,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, ARMED, COUNT, HOLD, FINISHED} state_t;
  localparam logic [4:0] KMAX = 5'(Dimension);
  state_t state;
  logic [ADDR_W-1:0] filter_base;
  logic [4:0] issued, ks_eff;
  logic [FW-1:0] nf_eff;
  logic [3:0] flag_cnt;
  logic last_tap, last_filter, hold;
  // tap and issued always move together, so one counter serves both
  always_comb begin
    last_tap = issued + 5'd1 == ks_eff;
    last_filter = filter_idx + FW'(1) == nf_eff;
    hold = state == HOLD;
  end
  // sequencer state, address and status registers; start > next_filter > rewind > en
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      filter_base <= '0;
      issued <= '0;
      ks_eff <= '0;
      nf_eff <= '0;
      flag_cnt <= '0;
      addr <= '0;
      filter_idx <= '0;
      weight_counter_done <= 1'b0;
      weight_flag_1per16 <= 1'b0;
      all_filters_done <= 1'b0;
      busy <= 1'b0;
    end else begin
      weight_flag_1per16 <= 1'b0;
      if (start) begin
        state <= ARMED;
        ks_eff <= kernel_size == 5'd0 ? 5'd1 : (kernel_size > KMAX ? KMAX : kernel_size);
        nf_eff <= num_filters == '0 ? FW'(1) : num_filters;
        filter_base <= base_addr;
        addr <= base_addr;
        issued <= '0;
        filter_idx <= '0;
        flag_cnt <= '0;
        weight_counter_done <= 1'b0;
        all_filters_done <= 1'b0;
        busy <= 1'b1;
      end else if (hold && next_filter && last_filter) begin
        state <= FINISHED;
        all_filters_done <= 1'b1;
        busy <= 1'b0;
      end else if (hold && next_filter) begin
        state <= ARMED;
        filter_idx <= filter_idx + FW'(1);
        filter_base <= filter_base + ADDR_W'(ks_eff);
        addr <= filter_base + ADDR_W'(ks_eff);
        issued <= '0;
        weight_counter_done <= 1'b0;
      end else if (hold && rewind) begin
        state <= ARMED;
        addr <= filter_base;
        issued <= '0;
        weight_counter_done <= 1'b0;
      end else if ((state == ARMED || state == COUNT) && en) begin
        state <= last_tap ? HOLD : COUNT;
        issued <= issued + 5'd1;
        addr <= last_tap ? addr : filter_base + ADDR_W'(issued) + ADDR_W'(1);
        flag_cnt <= flag_cnt + 4'd1;
        weight_flag_1per16 <= flag_cnt == 4'd15;
        weight_counter_done <= last_tap;
      end
    end
endmodule

// File: doc/weight_addr_sequencer.md
# weight_addr_sequencer

Weight-BRAM read-address generator for the conv datapath. Sits directly upstream of the filter microsequencer: it consumes the microsequencer's `en_weight_counter` and drives the shared port-B read address of the `Dimension` weight BRAMs. It returns `weight_counter_done` and `weight_flag_1per16` to the microsequencer, and steps through `num_filters` consecutive filters stored back-to-back in BRAM.

## Interface
- `ADDR_W`, 10, weight BRAM address width
- `Dimension`, 16, systolic width; also the maximum kernel size
- `FW`, 8, filter index width
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  pulse; latch config and begin at filter 0
- `en`  in  1  issue-one-address strobe (from `en_weight_counter`)
- `rewind`  in  1  pulse; re-issue the current filter from tap 0
- `next_filter`  in  1  pulse; advance to the next filter
- `kernel_size`  in  5  taps per filter; sampled on `start`
- `num_filters`  in  FW  filters in the job; sampled on `start`
- `base_addr`  in  ADDR_W  BRAM address of filter 0, tap 0; sampled on `start`
- `addr`  out  ADDR_W  registered BRAM read address
- `weight_counter_done`  out  1  level; all taps of the current filter issued
- `weight_flag_1per16`  out  1  one-cycle pulse per 16 issued addresses
- `filter_idx`  out  FW  current filter index
- `all_filters_done`  out  1  level; job complete
- `busy`  out  1  high in ARMED, COUNT and HOLD

## Operation
- Config sanitising at `start`:
  - `ks_eff` = `kernel_size` clamped to the range 1..`Dimension`. Input 0 maps to 1; inputs above `Dimension` map to `Dimension`.
  - `nf_eff` = `num_filters`, with 0 mapped to 1.
- States and transitions:
  - IDLE: `start` → ARMED.
  - ARMED: `en` → COUNT.
  - COUNT: `issued` reaches `ks_eff` → HOLD.
  - HOLD:
    - `rewind` → ARMED.
    - `next_filter` with `filter_idx+1 < nf_eff` → ARMED.
    - `next_filter` with `filter_idx+1 == nf_eff` → FINISHED.
  - FINISHED: `start` → ARMED.
- On `start` (in any state): `filter_base` ← `base_addr`, `tap` ← 0, `addr` ← `base_addr`, `issued` ← 0, `filter_idx` ← 0, flag counter ← 0. `done` and `all_filters_done` clear.
- Address issue (`en`=1 in ARMED or COUNT):
  - The current `addr` is the address read by the BRAM.
  - `issued` increments and `tap` increments.
  - `addr` ← `filter_base + tap + 1`. If that was the last tap, `addr` holds instead.
- The cycle in which `issued` becomes `ks_eff`: `weight_counter_done` ← 1 on the next clock, and the state moves to HOLD.
- In HOLD, `en` is ignored and `addr` holds the last tap address.
- `rewind` (HOLD only): `tap` ← 0, `issued` ← 0, `addr` ← `filter_base`, done ← 0. `filter_idx` is unchanged.
- `next_filter` (HOLD only), not last filter: `filter_idx` +1, `filter_base` += `ks_eff`, `addr` ← new `filter_base`, `tap` ← 0, `issued` ← 0, done ← 0.
- `next_filter` (HOLD only), last filter: `all_filters_done` ← 1 and `addr` holds.
- Address arithmetic is modulo 2^ADDR_W. Wrap is silent; there is no error output.
- Flag counter:
  - 4-bit, counts issued addresses across the whole job. It is not cleared by `next_filter` or `rewind`.
  - When it wraps 15→0, `weight_flag_1per16` pulses high for one cycle on the following clock.
- Priority for simultaneous inputs: `start` > `next_filter` > `rewind` > `en`.
- Ignored inputs:
  - `rewind` and `next_filter` outside HOLD.
  - `en` in IDLE, HOLD and FINISHED.

## Timing
- Reset values: state IDLE; `addr`=0, `filter_idx`=0; all 1-bit outputs 0; internal counters 0.
- Reset asserted mid-COUNT aborts immediately to the reset values. No output glitches beyond the asynchronous clear.
- All outputs are registered; there is no combinational path from any input to any output.
- `addr` advances on the clock edge that samples `en`. BRAM read latency (1 cycle) is absorbed by the microsequencer.
- `weight_counter_done` latency: it rises exactly 1 cycle after the clock edge that samples the `ks_eff`-th `en`.
- For `ks_eff`=1, the first `en` in ARMED both issues the only tap and completes the filter, so done rises on the next cycle.
- After `rewind` or `next_filter`, the first new address is presented in the following cycle. There are no bubble cycles inside a filter.

## Test plan
- Basic two-filter job: `base_addr`=0x010, `kernel_size`=3, `num_filters`=2, `en` held high.
  - Required: `addr` 0x010, 0x011, 0x012; done rises 1 cycle after the 3rd `en`.
  - `next_filter` → `addr`=0x013, `filter_idx`=1.
  - After the second done, `next_filter` → `all_filters_done`=1, `busy`=0.
- Clamping and flag: `kernel_size`=20 (clamps to 16), `num_filters`=3, continuous `en`.
  - Required: 16 issues per filter; `weight_flag_1per16` pulses exactly 3 times, one cycle after the 16th, 32nd and 48th issue.
- Address wrap: `base_addr`=0x3FE, `kernel_size`=4.
  - Required: `addr` 0x3FE, 0x3FF, 0x000, 0x001, then done.
- Rewind: after done on filter 0 with `base_addr`=0x020 and `kernel_size`=5, pulse `rewind`.
  - Required: `addr` returns to 0x020 and re-issues 0x020–0x024; `filter_idx` stays 0.
- Simultaneous events and reset:
  - `start` and `next_filter` in the same HOLD cycle → `start` wins: `filter_idx`=0, `addr`=new `base_addr`.
  - `rst` low during COUNT → all outputs 0 immediately; state is IDLE.
